// File: rtl/command_bus_master.sv
// Host-side initiator for the GPU command bus: turns a one-cycle request into the
// sync / command / data edge sequence, with an optional read-back window.
module command_bus_master #(
   parameter int unsigned CLK_DIV = 2,
   parameter int unsigned RD_WAIT = 2
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic [15:0] i_req_cmd,
   input  logic [15:0] i_req_data,
   input  logic        i_req_read,
   output logic        o_done,
   output logic [15:0] o_read_data,
   output logic        o_read_valid,
   output logic        o_command_clk,
   output logic        o_output_enable,
   output logic [15:0] o_bus_out,
   output logic        o_bus_oe,
   input  logic [15:0] i_bus_in
);

   localparam int unsigned CNT_W = 8;
   localparam int unsigned BUS_W = 16;
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_WAIT - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_SYNC_LO,
      S_SYNC_HI,
      S_CMD_LO,
      S_CMD_HI,
      S_DATA_LO,
      S_DATA_HI,
      S_TURN,
      S_RD,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [BUS_W-1:0] r_cmd;
   logic [BUS_W-1:0] r_data;
   logic             r_read;
   logic             r_req_ready;
   logic             r_done;
   logic [BUS_W-1:0] r_read_data;
   logic             r_read_valid;
   logic             r_command_clk;
   logic             r_output_enable;
   logic [BUS_W-1:0] r_bus_out;
   logic             r_bus_oe;
   logic             w_phase_end;

   assign w_phase_end = (r_cnt == '0);

   // Outputs are computed for the state being entered, so every bus pin is a flop.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state         <= S_IDLE;
         r_cnt           <= '0;
         r_cmd           <= '0;
         r_data          <= '0;
         r_read          <= 1'b0;
         r_req_ready     <= 1'b1;
         r_done          <= 1'b0;
         r_read_data     <= '0;
         r_read_valid    <= 1'b0;
         r_command_clk   <= 1'b0;
         r_output_enable <= 1'b0;
         r_bus_out       <= '0;
         r_bus_oe        <= 1'b0;
      end else begin
         r_done       <= 1'b0;
         r_read_valid <= 1'b0;
         if (r_state != S_IDLE && r_state != S_DONE && !w_phase_end) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
         case (r_state)
            S_IDLE: begin
               if (i_req_valid) begin
                  r_cmd           <= i_req_cmd;
                  r_data          <= i_req_data;
                  r_read          <= i_req_read;
                  r_req_ready     <= 1'b0;
                  r_output_enable <= 1'b1;
                  r_command_clk   <= 1'b0;
                  r_bus_oe        <= 1'b0;
                  r_cnt           <= DIV_LOAD;
                  r_state         <= S_SYNC_LO;
               end
            end
            S_SYNC_LO: begin
               if (w_phase_end) begin
                  r_command_clk <= 1'b1;
                  r_cnt         <= DIV_LOAD;
                  r_state       <= S_SYNC_HI;
               end
            end
            S_SYNC_HI: begin
               if (w_phase_end) begin
                  r_command_clk   <= 1'b0;
                  r_output_enable <= 1'b0;
                  r_bus_out       <= r_cmd;
                  r_cnt           <= DIV_LOAD;
                  r_state         <= S_CMD_LO;
               end
            end
            S_CMD_LO: begin
               // Pad driver turns on one cycle after OE has dropped.
               r_bus_oe <= 1'b1;
               if (w_phase_end) begin
                  r_command_clk <= 1'b1;
                  r_cnt         <= DIV_LOAD;
                  r_state       <= S_CMD_HI;
               end
            end
            S_CMD_HI: begin
               if (w_phase_end) begin
                  r_command_clk <= 1'b0;
                  r_bus_out     <= r_data;
                  r_cnt         <= DIV_LOAD;
                  r_state       <= S_DATA_LO;
               end
            end
            S_DATA_LO: begin
               if (w_phase_end) begin
                  r_command_clk <= 1'b1;
                  r_cnt         <= DIV_LOAD;
                  r_state       <= S_DATA_HI;
               end
            end
            S_DATA_HI: begin
               if (w_phase_end) begin
                  r_command_clk <= 1'b0;
                  r_bus_oe      <= 1'b0;
                  if (r_read) begin
                     r_cnt   <= DIV_LOAD;
                     r_state <= S_TURN;
                  end else begin
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end
               end
            end
            S_TURN: begin
               if (w_phase_end) begin
                  r_output_enable <= 1'b1;
                  r_cnt           <= RD_LOAD;
                  r_state         <= S_RD;
               end
            end
            S_RD: begin
               if (w_phase_end) begin
                  r_read_data     <= i_bus_in;
                  r_read_valid    <= 1'b1;
                  r_done          <= 1'b1;
                  r_output_enable <= 1'b0;
                  r_state         <= S_DONE;
               end
            end
            S_DONE: begin
               r_req_ready <= 1'b1;
               r_bus_out   <= '0;
               r_state     <= S_IDLE;
            end
            default: begin
               r_req_ready     <= 1'b1;
               r_command_clk   <= 1'b0;
               r_output_enable <= 1'b0;
               r_bus_oe        <= 1'b0;
               r_bus_out       <= '0;
               r_state         <= S_IDLE;
            end
         endcase
      end
   end

   assign o_req_ready     = r_req_ready;
   assign o_done          = r_done;
   assign o_read_data     = r_read_data;
   assign o_read_valid    = r_read_valid;
   assign o_command_clk   = r_command_clk;
   assign o_output_enable = r_output_enable;
   assign o_bus_out       = r_bus_out;
   assign o_bus_oe        = r_bus_oe;

endmodule

// File: tb/tb_command_bus_master.sv
// Bench for command_bus_master: two instances (D=2/R=3 and D=3/R=1) checked cycle by cycle
// against the transaction timeline and a GPU command-receiver model.
module tb_command_bus_master;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] req_cmd, req_data;
   logic        req_read;
   logic        valid_a, valid_b;
   logic [15:0] bus_in_a, bus_in_b;

   logic        ready_a, done_a, rvalid_a, cclk_a, oe_a, boe_a;
   logic [15:0] rdata_a, bout_a;
   logic        ready_b, done_b, rvalid_b, cclk_b, oe_b, boe_b;
   logic [15:0] rdata_b, bout_b;

   always #5 clk = ~clk;

   command_bus_master #(.CLK_DIV(2), .RD_WAIT(3)) u_dut_a (
      .i_clk(clk), .i_reset(reset), .i_req_valid(valid_a), .o_req_ready(ready_a),
      .i_req_cmd(req_cmd), .i_req_data(req_data), .i_req_read(req_read),
      .o_done(done_a), .o_read_data(rdata_a), .o_read_valid(rvalid_a),
      .o_command_clk(cclk_a), .o_output_enable(oe_a), .o_bus_out(bout_a),
      .o_bus_oe(boe_a), .i_bus_in(bus_in_a)
   );

   command_bus_master #(.CLK_DIV(3), .RD_WAIT(1)) u_dut_b (
      .i_clk(clk), .i_reset(reset), .i_req_valid(valid_b), .o_req_ready(ready_b),
      .i_req_cmd(req_cmd), .i_req_data(req_data), .i_req_read(req_read),
      .o_done(done_b), .o_read_data(rdata_b), .o_read_valid(rvalid_b),
      .o_command_clk(cclk_b), .o_output_enable(oe_b), .o_bus_out(bout_b),
      .o_bus_oe(boe_b), .i_bus_in(bus_in_b)
   );

   int          checks = 0;
   int          errors = 0;
   int          sel = 0;
   int          rises = 0;

   logic        s_ready, s_done, s_rvalid, s_cclk, s_oe, s_boe;
   logic [15:0] s_rdata, s_bout;
   logic        prev_cclk [2];

   // GPU receiver model: sync edge (OE high) re-arms for a command, then cmd, then data.
   bit          gpu_want_cmd [2];
   logic [15:0] gpu_cmd [2];
   logic [15:0] gpu_data [2];
   int          gpu_pairs [2];
   logic [15:0] exp_rdata [2];

   task automatic set_valid(input logic v);
      if (sel == 0) valid_a = v;
      else valid_b = v;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (sel == 0) begin
         s_ready = ready_a; s_done = done_a; s_rvalid = rvalid_a; s_cclk = cclk_a;
         s_oe = oe_a; s_boe = boe_a; s_rdata = rdata_a; s_bout = bout_a;
      end else begin
         s_ready = ready_b; s_done = done_b; s_rvalid = rvalid_b; s_cclk = cclk_b;
         s_oe = oe_b; s_boe = boe_b; s_rdata = rdata_b; s_bout = bout_b;
      end
      if (s_cclk && !prev_cclk[sel]) begin
         rises++;
         if (s_oe) gpu_want_cmd[sel] = 1'b1;
         else if (gpu_want_cmd[sel]) begin
            gpu_cmd[sel] = s_bout;
            gpu_want_cmd[sel] = 1'b0;
         end else begin
            gpu_data[sel] = s_bout;
            gpu_want_cmd[sel] = 1'b1;
            gpu_pairs[sel]++;
         end
      end
      prev_cclk[sel] = s_cclk;
   endtask

   // One full transaction with per-cycle expectations derived from the timeline.
   task automatic run_txn(input logic [15:0] cmd, input logic [15:0] data, input logic rd,
                          input logic [15:0] rval, input bit hold, input int pulse_at);
      int d, r, last, pairs0;
      logic e_cclk, e_oe, e_boe, e_done, e_rvalid, e_ready;
      d = (sel == 0) ? 2 : 3;
      r = (sel == 0) ? 3 : 1;
      last = rd ? (7 * d + r + 1) : (6 * d + 1);
      pairs0 = gpu_pairs[sel];
      rises = 0;
      req_cmd = cmd; req_data = data; req_read = rd;
      set_valid(1'b1);
      for (int n = 1; n <= last + 1; n++) begin
         tick();
         if (!hold) begin
            set_valid(n == pulse_at);
            if (n == pulse_at) begin
               req_cmd = ~cmd; req_data = ~data; req_read = ~rd;
            end
         end
         e_cclk   = (n > d && n <= 2 * d) || (n > 3 * d && n <= 4 * d) || (n > 5 * d && n <= 6 * d);
         e_oe     = (n <= 2 * d) || (rd && n > 7 * d && n <= 7 * d + r);
         e_boe    = (n >= 2 * d + 2) && (n <= 6 * d);
         e_done   = (n == last);
         e_rvalid = rd && (n == last);
         e_ready  = (n == last + 1);
         if (rd && n == last) exp_rdata[sel] = rval;
         checks++;
         if ({s_ready, s_done, s_rvalid, s_cclk, s_oe, s_boe} !==
             {e_ready, e_done, e_rvalid, e_cclk, e_oe, e_boe}) begin
            errors++;
            $display("FAIL ctrl dut=%0d n=%0d got rdy/done/rv/cclk/oe/boe=%b exp=%b", sel, n,
                     {s_ready, s_done, s_rvalid, s_cclk, s_oe, s_boe},
                     {e_ready, e_done, e_rvalid, e_cclk, e_oe, e_boe});
         end
         checks++;
         if (s_rdata !== exp_rdata[sel]) begin
            errors++;
            $display("FAIL read_data dut=%0d n=%0d got=%h exp=%h", sel, n, s_rdata, exp_rdata[sel]);
         end
         if (n >= 2 * d + 2 && n <= 4 * d) begin
            checks++;
            if (s_bout !== cmd) begin
               errors++;
               $display("FAIL bus_cmd dut=%0d n=%0d got=%h exp=%h", sel, n, s_bout, cmd);
            end
         end
         if (n >= 4 * d + 2 && n <= 6 * d) begin
            checks++;
            if (s_bout !== data) begin
               errors++;
               $display("FAIL bus_data dut=%0d n=%0d got=%h exp=%h", sel, n, s_bout, data);
            end
         end
         if (s_oe && s_boe) begin
            errors++;
            $display("FAIL contention dut=%0d n=%0d oe=1 bus_oe=1", sel, n);
         end
         if (sel == 0) bus_in_a = (s_oe && n > 7 * d) ? rval : ~rval;
         else bus_in_b = (s_oe && n > 7 * d) ? rval : ~rval;
      end
      checks++;
      if (rises !== 3) begin
         errors++;
         $display("FAIL edge_count dut=%0d got=%0d exp=3", sel, rises);
      end
      checks++;
      if (gpu_pairs[sel] !== pairs0 + 1 || gpu_cmd[sel] !== cmd || gpu_data[sel] !== data) begin
         errors++;
         $display("FAIL gpu_rx dut=%0d got pairs=%0d cmd=%h data=%h exp pairs=%0d cmd=%h data=%h",
                  sel, gpu_pairs[sel] - pairs0, gpu_cmd[sel], gpu_data[sel], 1, cmd, data);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; valid_a = 1'b0; valid_b = 1'b0;
      req_cmd = '0; req_data = '0; req_read = 1'b0; bus_in_a = '0; bus_in_b = '0;
      for (int k = 0; k < 2; k++) begin
         gpu_want_cmd[k] = 1'b1; gpu_pairs[k] = 0; exp_rdata[k] = '0; prev_cclk[k] = 1'b0;
      end
      for (int i = 0; i < 3; i++) tick();
      reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         sel = k;
         tick();
         checks++;
         if ({s_ready, s_done, s_rvalid, s_cclk, s_oe, s_boe, s_rdata, s_bout} !== {6'b100000, 32'h0}) begin
            errors++;
            $display("FAIL reset_vals dut=%0d got=%b/%h/%h exp=100000/0000/0000", k,
                     {s_ready, s_done, s_rvalid, s_cclk, s_oe, s_boe}, s_rdata, s_bout);
         end
      end
      sel = 0;
   endtask

   task automatic test_write();
      sel = 0;
      run_txn(16'h1234, 16'hABCD, 1'b0, 16'h0, 1'b0, 0);
   endtask

   task automatic test_read();
      sel = 0;
      run_txn(16'h00C3, 16'h5500, 1'b1, 16'hBEEF, 1'b0, 0);
   endtask

   task automatic test_desync();
      sel = 0;
      gpu_want_cmd[0] = 1'b0;
      run_txn(16'h0001, 16'h0002, 1'b0, 16'h0, 1'b0, 0);
   endtask

   task automatic test_reset_mid();
      sel = 0;
      rises = 0;
      req_cmd = 16'h7777; req_data = 16'h8888; req_read = 1'b0;
      set_valid(1'b1);
      for (int n = 1; n <= 8; n++) begin
         tick();
         set_valid(1'b0);
      end
      reset = 1'b1;
      for (int n = 9; n <= 11; n++) begin
         tick();
         checks++;
         if ({s_ready, s_done, s_rvalid, s_cclk, s_oe, s_boe, s_rdata, s_bout} !== {6'b100000, 32'h0}) begin
            errors++;
            $display("FAIL reset_mid n=%0d got=%b/%h/%h exp=100000/0000/0000", n,
                     {s_ready, s_done, s_rvalid, s_cclk, s_oe, s_boe}, s_rdata, s_bout);
         end
      end
      reset = 1'b0;
      exp_rdata[0] = '0; exp_rdata[1] = '0;
      for (int n = 0; n < 3; n++) begin
         tick();
         checks++;
         if ({s_ready, s_done, s_cclk, s_oe} !== 4'b1000) begin
            errors++;
            $display("FAIL after_reset n=%0d got rdy/done/cclk/oe=%b exp=1000", n,
                     {s_ready, s_done, s_cclk, s_oe});
         end
      end
   endtask

   task automatic test_back_to_back();
      sel = 0;
      run_txn(16'hC0DE, 16'h0F0F, 1'b0, 16'h0, 1'b1, 0);
      run_txn(16'h3C3C, 16'hA5A5, 1'b0, 16'h0, 1'b0, 6);
      rises = 0;
      for (int n = 0; n < 4; n++) begin
         tick();
         checks++;
         if ({s_ready, s_done, s_cclk, s_oe} !== 4'b1000) begin
            errors++;
            $display("FAIL idle_after_b2b n=%0d got rdy/done/cclk/oe=%b exp=1000", n,
                     {s_ready, s_done, s_cclk, s_oe});
         end
      end
   endtask

   task automatic test_d3_read();
      sel = 1;
      run_txn(16'h4321, 16'h8765, 1'b1, 16'h2468, 1'b0, 0);
      run_txn(16'h1111, 16'h2222, 1'b0, 16'h0, 1'b0, 0);
      sel = 0;
   endtask

   task automatic test_random();
      logic [15:0] c, dt, rv;
      logic rd;
      for (int i = 0; i < 8; i++) begin
         sel = int'($urandom_range(0, 1));
         c  = 16'($urandom);
         dt = 16'($urandom);
         rv = 16'($urandom);
         rd = 1'($urandom_range(0, 1));
         run_txn(c, dt, rd, rv, 1'b0, (i % 3 == 0) ? 4 : 0);
      end
      sel = 0;
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_reset_mid();
      test_desync();
      test_back_to_back();
      test_d3_read();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/command_bus_master.md
# command_bus_master

Host-side initiator for the GPU command bus. It turns a single-cycle request (command word plus data word, optionally followed by a read-back) into the bus waveform the GPU command interface samples:
- a sync edge with `outputEnable` high;
- a command word on the first `commandClk` rising edge with `outputEnable` low;
- a data word on the second such edge;
- for reads, an `outputEnable`-high window during which the GPU drives the bus and the block captures it.

It sits in the external-controller FPGA/bridge and in the GPU testbench as the bus driver.

## Interface
- `CLK_DIV`, 2: system clocks per `commandClk` half-period. Legal range 2..255.
- `RD_WAIT`, 2: system clocks `outputEnable` is held high in a read before sampling. Legal range 1..255.
- `clk` input 1: system clock. All logic is on the rising edge.
- `reset` input 1: synchronous, active-high. It has priority over all other inputs.
- `reqValid` input 1: request strobe.
- `reqReady` output 1: high in IDLE only. A request is accepted on an edge where `reqValid && reqReady`.
- `reqCmd` input 16: command word, captured at accept.
- `reqData` input 16: data word, captured at accept.
- `reqRead` input 1: captured at accept. 1 appends a read-back phase.
- `done` output 1: one-cycle pulse at transaction end.
- `readData` output 16: word captured in the read phase. Holds until the next read completes.
- `readValid` output 1: one-cycle pulse coincident with `done` on read transactions only.
- `commandClk` output 1: bus clock to the GPU.
- `outputEnable` output 1: bus direction. 1 means the GPU drives `dataInOut`.
- `busOut` output 16: value the pad drives onto `dataInOut`.
- `busOe` output 1: pad tri-state enable for `busOut`.
- `busIn` input 16: pad input from `dataInOut`.

## Operation
- States and their outputs:
  - IDLE: all bus outputs at their reset values.
  - SYNC_LO: OE=1, clk=0, busOe=0.
  - SYNC_HI: OE=1, clk=1, busOe=0.
  - CMD_LO: OE=0, clk=0, busOut=cmd.
  - CMD_HI: OE=0, clk=1, busOut=cmd.
  - DATA_LO: OE=0, clk=0, busOut=data.
  - DATA_HI: OE=0, clk=1, busOut=data.
  - TURN: OE=0, clk=0, busOe=0.
  - RD: OE=1, clk=0, busOe=0.
  - DONE.
- SYNC_LO, SYNC_HI, CMD_LO, CMD_HI, DATA_LO, DATA_HI and TURN each last exactly `CLK_DIV` cycles, counted by a phase counter that reloads on every state change.
- RD lasts `RD_WAIT` cycles.
- Transitions:
  - IDLE goes to SYNC_LO on accept.
  - The sequence then runs SYNC_LO, SYNC_HI, CMD_LO, CMD_HI, DATA_LO, DATA_HI.
  - After DATA_HI: to DONE if write, to TURN if read.
  - TURN goes to RD, then RD goes to DONE.
  - DONE lasts 1 cycle, then goes to IDLE.
- The SYNC rising edge (OE high) forces the receiver's command/data sequencer back to expecting a command. Every transaction starts with it, so a lost or partial prior transaction never misaligns cmd and data.
- Contention rule: `busOe` is 0 whenever `outputEnable` is 1. `busOe` rises on the 2nd cycle of CMD_LO, one cycle after OE falls. `busOe` falls on the first cycle of TURN (read) or DONE (write).
- `busOut` changes only while `commandClk` is 0. It is stable for at least `CLK_DIV-1` cycles before and `CLK_DIV` cycles after each rising edge.
- `readData` is loaded from `busIn` on the last RD cycle.
- Reset mid-transaction: on the next edge, return to IDLE with all outputs at reset values. No `done` or `readValid` is produced and the request is dropped.
- `reqValid` while busy is ignored. It is not queued.

## Timing
- Reset values:
  - `reqReady`=1 (IDLE)
  - `done`=0
  - `readValid`=0
  - `readData`=0
  - `commandClk`=0
  - `outputEnable`=0
  - `busOe`=0
  - `busOut`=0
- Timeline, with D=`CLK_DIV` and R=`RD_WAIT`, and cycle 0 the accept edge:
  - Cycles 1..D: SYNC_LO.
  - D+1..2D: SYNC_HI.
  - 2D+1..3D: CMD_LO.
  - 3D+1..4D: CMD_HI.
  - 4D+1..5D: DATA_LO.
  - 5D+1..6D: DATA_HI.
- Write: `done` is high in cycle 6D+1. `reqReady` returns in cycle 6D+2.
- Read:
  - TURN occupies 6D+1..7D.
  - RD occupies 7D+1..7D+R.
  - `busIn` is sampled at the end of cycle 7D+R.
  - `done`=`readValid`=1 in cycle 7D+R+1, with `readData` valid from that cycle.
- Back-to-back: a request held high during DONE is accepted in the first IDLE cycle. This gives one idle bus cycle between transactions.
- `commandClk` rising edges per transaction: exactly 3 (sync, cmd, data).

## Test plan
- Write, D=2: `reqCmd`=0x1234, `reqData`=0xABCD. Expect `commandClk` rises at cycles 3, 7 and 11. Expect `busOut`=0x1234 at the 2nd rise and 0xABCD at the 3rd. Expect `done` at cycle 13. A GPU command-interface model reports command 0x1234 and data 0xABCD.
- Read, D=2, R=3: the model drives 0xBEEF when OE=1. Expect `readValid`, `done` and `readData`=0xBEEF at cycle 18. Expect `busOe`=0 on every cycle where OE=1.
- Desync recovery: pre-load the receiver model with an orphan command edge, then issue write 0x0001/0x0002. The receiver outputs cmd 0x0001 and data 0x0002.
- Reset asserted at cycle 8 of a write. Expect all outputs at reset values from cycle 9, no `done`, and `reqReady`=1 after reset deasserts.
- Back-to-back writes with `reqValid` held high, plus a `reqValid` pulse mid-transaction. Expect exactly 2 transactions, each with 3 clock edges, and the mid-transaction pulse ignored.
- D=3, R=1 read. Expect phase lengths of 3 and `done` at cycle 23.
